// File: rtl/system_memory_router_pkg.sv
// rtl/system_memory_router_pkg.sv - shared types and address decode for the memory router
package system_memory_router_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 8;
  localparam int MAX_CH = 4;

  typedef enum logic [2:0] {
    IDLE,
    BRAM_RD,
    SD_REQ,
    SD_WAIT,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    REG_BRAM,
    REG_SDRAM,
    REG_UNMAPPED
  } region_t;

  typedef struct packed {
    region_t            region;
    logic [1:0]         ch;
    logic [ADDR_W-1:0]  offset;
  } decode_t;

  // Low window goes to BRAM; above it, the offset past the window picks an SDRAM channel.
  function automatic decode_t decode_addr(input logic [ADDR_W-1:0] addr,
                                          input int bram_width,
                                          input int ch_shift,
                                          input int channels);
    decode_t d;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] chf;
    off = addr - (27'd1 << bram_width);
    chf = off >> ch_shift;
    d.region = REG_UNMAPPED;
    d.ch     = 2'd0;
    d.offset = off & ((27'd1 << ch_shift) - 27'd1);
    if ((addr >> bram_width) == 27'd0) begin
      d.region = REG_BRAM;
      d.offset = addr;
    end else if (chf < 27'(channels)) begin
      d.region = REG_SDRAM;
      d.ch     = chf[1:0];
    end
    return d;
  endfunction

endpackage

// File: rtl/system_memory_router_if.sv
// rtl/system_memory_router_if.sv - byte memory bus shared by sources and SDRAM channels
interface memory_bus_if;
  logic [26:0] addr;
  logic [7:0]  data;
  logic        rnw;
  logic        ram_cs;
  logic        sram_cs;
  logic [7:0]  q;
  logic        sdram_ready;
  logic        sdram_done;

  modport ram_mp (
    input  addr, data, rnw, ram_cs, sram_cs,
    output q, sdram_ready, sdram_done
  );

  modport device_mp (
    output addr, data, rnw, ram_cs, sram_cs,
    input  q, sdram_ready, sdram_done
  );
endinterface

// File: rtl/dpram.sv
// rtl/dpram.sv - dual-port block RAM, registered read; port B is read-only
module dpram #(
  parameter string mem_name   = "",
  parameter int    addr_width = 8,
  parameter int    data_width = 8
) (
  input  logic                  clock_a,
  input  logic [addr_width-1:0] address_a,
  input  logic [data_width-1:0] data_a,
  input  logic                  wren_a,
  output logic [data_width-1:0] q_a,
  input  logic                  clock_b,
  input  logic [addr_width-1:0] address_b,
  output logic [data_width-1:0] q_b
);

  logic [data_width-1:0] mem [2**addr_width];

  // Port A: write plus read-before-write registered output
  always_ff @(posedge clock_a) begin
    if (wren_a) mem[address_a] <= data_a;
    q_a <= mem[address_a];
  end

  // Port B: registered read only
  always_ff @(posedge clock_b) begin
    q_b <= mem[address_b];
  end

endmodule

// File: rtl/system_memory_router.sv
// rtl/system_memory_router.sv - routes MSX/upload byte accesses to BRAM or SDRAM channels
module system_memory_router
  import system_memory_router_pkg::*;
#(
  parameter int BRAM_WIDTH     = 18,
  parameter int SDRAM_CHANNELS = 1,
  parameter int CH_SHIFT       = 25,
  parameter int TIMEOUT        = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upload,
  memory_bus_if.ram_mp      memory_bus_msx,
  memory_bus_if.ram_mp      memory_bus_upload,
  memory_bus_if.device_mp   memory_bus_sdram [SDRAM_CHANNELS],
  output logic              msx_ack,
  output logic              upload_ack,
  output logic              timeout_err
);

  state_t state, state_nx;

  logic                  src_r;          // 1 = upload bus owns the current access
  logic                  rnw_r;
  logic [7:0]            data_r;
  logic [7:0]            q_r;
  logic [BRAM_WIDTH-1:0] bram_addr_r;
  logic [CH_SHIFT-1:0]   chan_addr_r;
  logic [1:0]            ch_r;
  logic [7:0]            wd;
  logic                  served_msx, served_up;

  logic [26:0] live_addr;
  logic [7:0]  live_data;
  logic        live_rnw, live_cs, live_served, req;
  decode_t     live_dec;

  logic [MAX_CH-1:0] ch_ready, ch_done;
  logic [7:0]        ch_q [MAX_CH];
  logic [1:0]        cur_ch;
  logic              ready_cur, done_cur, wd_hit, timed_out;
  logic              chan_active, bram_wren;

  logic [BRAM_WIDTH-1:0] bram_addr;
  logic [7:0]            bram_q, bram_q_b;

  // Source selection only matters while idle; afterwards everything runs from latched copies.
  assign live_addr   = upload ? memory_bus_upload.addr   : memory_bus_msx.addr;
  assign live_data   = upload ? memory_bus_upload.data   : memory_bus_msx.data;
  assign live_rnw    = upload ? memory_bus_upload.rnw    : memory_bus_msx.rnw;
  assign live_cs     = upload ? memory_bus_upload.ram_cs : memory_bus_msx.ram_cs;
  assign live_served = upload ? served_up                : served_msx;
  assign req         = (state == IDLE) && live_cs && !live_served;
  assign live_dec    = decode_addr(live_addr, BRAM_WIDTH, CH_SHIFT, SDRAM_CHANNELS);

  // Channel fan-out; unused slots read as idle so the 2-bit channel index is always safe.
  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < SDRAM_CHANNELS) begin : g_on
      assign memory_bus_sdram[i].ram_cs  = chan_active && (ch_r == 2'(i));
      assign memory_bus_sdram[i].sram_cs = 1'b0;
      assign memory_bus_sdram[i].addr    = 27'(chan_addr_r);
      assign memory_bus_sdram[i].data    = data_r;
      assign memory_bus_sdram[i].rnw     = rnw_r;
      assign ch_ready[i] = memory_bus_sdram[i].sdram_ready;
      assign ch_done[i]  = memory_bus_sdram[i].sdram_done;
      assign ch_q[i]     = memory_bus_sdram[i].q;
    end else begin : g_off
      assign ch_ready[i] = 1'b0;
      assign ch_done[i]  = 1'b0;
      assign ch_q[i]     = 8'hFF;
    end
  end

  assign cur_ch    = (state == IDLE) ? 2'd0 : ch_r;
  assign ready_cur = ch_ready[ch_r];
  assign done_cur  = ch_done[ch_r];
  assign wd_hit    = chan_active && (wd == 8'(TIMEOUT));
  // A done arriving in the expiry cycle still counts as a real completion.
  assign timed_out = wd_hit && !((state == SD_WAIT) && done_cur);

  assign memory_bus_msx.q              = memory_bus_msx.ram_cs ? q_r : 8'hFF;
  assign memory_bus_msx.sdram_ready    = ch_ready[cur_ch];
  assign memory_bus_msx.sdram_done     = ch_done[cur_ch];
  assign memory_bus_upload.q           = memory_bus_upload.ram_cs ? q_r : 8'hFF;
  assign memory_bus_upload.sdram_ready = ch_ready[cur_ch];
  assign memory_bus_upload.sdram_done  = ch_done[cur_ch];

  // BRAM sees the live address while idle so a read launches in the accept cycle.
  assign bram_addr = (state == IDLE) ? live_addr[BRAM_WIDTH-1:0] : bram_addr_r;

  dpram #(
    .mem_name   ("SYSTEM"),
    .addr_width (BRAM_WIDTH),
    .data_width (8)
  ) u_bram (
    .clock_a   (clk),
    .address_a (bram_addr),
    .data_a    (live_data),
    .wren_a    (bram_wren),
    .q_a       (bram_q),
    .clock_b   (clk),
    .address_b ('0),
    .q_b       (bram_q_b)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_nx    = state;
    msx_ack     = 1'b0;
    upload_ack  = 1'b0;
    chan_active = 1'b0;
    bram_wren   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          unique case (live_dec.region)
            REG_BRAM: begin
              state_nx  = live_rnw ? BRAM_RD : ACK;
              bram_wren = !live_rnw;
            end
            REG_SDRAM: state_nx = SD_REQ;
            default:   state_nx = ACK;
          endcase
        end
      end
      BRAM_RD: state_nx = ACK;
      SD_REQ: begin
        chan_active = 1'b1;
        if (wd_hit)         state_nx = ACK;
        else if (ready_cur) state_nx = SD_WAIT;
      end
      SD_WAIT: begin
        chan_active = 1'b1;
        if (done_cur || wd_hit) state_nx = ACK;
      end
      ACK: begin
        msx_ack    = !src_r;
        upload_ack = src_r;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Access latch, read data, watchdog and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_r       <= 1'b0;
      rnw_r       <= 1'b1;
      data_r      <= 8'h00;
      q_r         <= 8'hFF;
      bram_addr_r <= '0;
      chan_addr_r <= '0;
      ch_r        <= 2'd0;
      wd          <= 8'd0;
      timeout_err <= 1'b0;
    end else begin
      if (req) begin
        src_r       <= upload;
        rnw_r       <= live_rnw;
        data_r      <= live_data;
        bram_addr_r <= live_addr[BRAM_WIDTH-1:0];
        chan_addr_r <= live_dec.offset[CH_SHIFT-1:0];
        ch_r        <= live_dec.ch;
        if ((live_dec.region == REG_UNMAPPED) && live_rnw) q_r <= 8'hFF;
      end
      if (state == BRAM_RD) q_r <= bram_q;
      if ((state == SD_WAIT) && done_cur && rnw_r) q_r <= ch_q[ch_r];
      if (timed_out) begin
        q_r         <= 8'hFF;
        timeout_err <= 1'b1;
      end
      wd <= chan_active ? wd + 8'd1 : 8'd0;
    end
  end

  // One access per chip-select assertion: served holds off re-issue until cs drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      served_msx <= 1'b0;
      served_up  <= 1'b0;
    end else begin
      if (!memory_bus_msx.ram_cs)             served_msx <= 1'b0;
      else if ((state == ACK) && !src_r)      served_msx <= 1'b1;
      if (!memory_bus_upload.ram_cs)          served_up  <= 1'b0;
      else if ((state == ACK) && src_r)       served_up  <= 1'b1;
    end
  end

endmodule
